alu_sequencer: RTL and testbench

//   Multi-cycle controller that sequences the shared 8-bit ALU (add/sub/mul) against the 32x16 memory.

---
 rtl/alu_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/operand/execute/write controller for the shared 8-bit ALU.
// Optional instr_count port enabled by ALU_SEQ_PERF_CNT_EN.
module alu_sequencer #(
  parameter logic [4:0]  PC_RESET     = 5'd0,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  pc,
  output logic [4:0]  address,
  output logic        readwriteN,
  output logic [15:0] data_out,
  input  logic [15:0] data_in,
  output logic [7:0]  first_alu,
  output logic [7:0]  second_alu,
  output logic        mul,
  output logic        sub,
  input  logic [7:0]  result_of_alu
`ifdef ALU_SEQ_PERF_CNT_EN
  ,
  output logic [15:0] instr_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_OPERAND,
    S_EXECUTE, S_WRITE, S_HALT
  } state_t;

  localparam logic [1:0] LAST = 2'(READ_LATENCY - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [4:0]  pc_q, pc_d;
  logic [4:0]  addr_q, addr_d;
  logic [15:4] ir_q, ir_d;
  logic [15:0] opr_q, opr_d;
  logic [7:0]  res_q, res_d;
  logic [15:0] dout_q, dout_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic        rw_q, rw_d, mul_q, mul_d, sub_q, sub_d;
  logic        unused_bits;

  assign unused_bits = ^data_in[3:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opr_d   = opr_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        if (cnt_q == LAST) begin
          ir_d    = data_in[15:4];
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_DECODE: begin
        cnt_d   = '0;
        state_d = (ir_q[15:14] == 2'b11) ? S_HALT : S_OPERAND;
      end
      S_OPERAND: begin
        if (cnt_q == LAST) begin
          opr_d   = data_in;
          state_d = S_EXECUTE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_EXECUTE: begin
        res_d   = result_of_alu;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        pc_d    = pc_q + 5'd1;
        cnt_d   = '0;
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          pc_d    = PC_RESET;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered: derive them from the state being entered.
    busy_d = !(state_d inside {S_IDLE, S_HALT});
    done_d = (state_d == S_HALT);
    rw_d   = (state_d == S_WRITE);
    dout_d = rw_d ? {8'h00, res_d} : 16'h0000;
    addr_d = addr_q;
    a_d    = '0;
    b_d    = '0;
    mul_d  = 1'b0;
    sub_d  = 1'b0;
    case (state_d)
      S_FETCH:   addr_d = pc_d;
      S_OPERAND: addr_d = ir_d[13:9];
      S_WRITE:   addr_d = ir_d[8:4];
      S_EXECUTE: begin
        a_d   = opr_d[15:8];
        b_d   = opr_d[7:0];
        sub_d = (ir_d[15:14] == 2'b01);
        mul_d = (ir_d[15:14] == 2'b10);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pc_q    <= PC_RESET;
      addr_q  <= '0;
      ir_q    <= '0;
      opr_q   <= '0;
      res_q   <= '0;
      dout_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rw_q    <= 1'b0;
      mul_q   <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      opr_q   <= opr_d;
      res_q   <= res_d;
      dout_q  <= dout_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rw_q    <= rw_d;
      mul_q   <= mul_d;
      sub_q   <= sub_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pc         = pc_q;
  assign address    = addr_q;
  assign readwriteN = rw_q;
  assign data_out   = dout_q;
  assign first_alu  = a_q;
  assign second_alu = b_q;
  assign mul        = mul_q;
  assign sub        = sub_q;

`ifdef ALU_SEQ_PERF_CNT_EN
  logic [15:0] icnt_q, icnt_d;

  always_comb begin
    icnt_d = icnt_q;
    if (state_q == S_HALT && start) icnt_d = '0;
    else if (state_q == S_WRITE)   icnt_d = icnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) icnt_q <= '0;
    else       icnt_q <= icnt_d;
  end

  assign instr_count = icnt_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (PC_RESET=0/RL=1, PC_RESET=31/RL=3)
// with bench-side memory and ALU, checked against an instruction-level model.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start_s [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic        rw_s    [2];
  logic        mul_s   [2];
  logic        sub_s   [2];
  logic [4:0]  pc_s    [2];
  logic [4:0]  addr_s  [2];
  logic [15:0] dout_s  [2];
  logic [15:0] din_s   [2];
  logic [7:0]  a_s     [2];
  logic [7:0]  b_s     [2];
  logic [7:0]  res_s   [2];
`ifdef ALU_SEQ_PERF_CNT_EN
  logic [15:0] icnt_s  [2];
`endif

  logic [15:0] mem [2][32];
  logic [15:0] img [32];
  logic [15:0] mm  [32];
  int          ld = 0;
  int          wcnt   [2];
  int          badrun [2];
  logic        rw_prev [2] = '{1'b0, 1'b0};

  int n_chk  = 0;
  int n_fail = 0;

  alu_sequencer #(.PC_RESET(5'd0), .READ_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .pc(pc_s[0]),
    .address(addr_s[0]), .readwriteN(rw_s[0]),
    .data_out(dout_s[0]), .data_in(din_s[0]),
    .first_alu(a_s[0]), .second_alu(b_s[0]),
    .mul(mul_s[0]), .sub(sub_s[0]),
    .result_of_alu(res_s[0])
`ifdef ALU_SEQ_PERF_CNT_EN
    , .instr_count(icnt_s[0])
`endif
  );

  alu_sequencer #(.PC_RESET(5'd31), .READ_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .pc(pc_s[1]),
    .address(addr_s[1]), .readwriteN(rw_s[1]),
    .data_out(dout_s[1]), .data_in(din_s[1]),
    .first_alu(a_s[1]), .second_alu(b_s[1]),
    .mul(mul_s[1]), .sub(sub_s[1]),
    .result_of_alu(res_s[1])
`ifdef ALU_SEQ_PERF_CNT_EN
    , .instr_count(icnt_s[1])
`endif
  );

  for (genvar g = 0; g < 2; g++) begin : g_env
    assign din_s[g] = mem[g][addr_s[g]];
    assign res_s[g] = mul_s[g] ? 8'(a_s[g] * b_s[g]) :
                      sub_s[g] ? 8'(a_s[g] - b_s[g]) :
                                 8'(a_s[g] + b_s[g]);
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ld == k + 1) begin
        for (int i = 0; i < 32; i++) mem[k][i] <= img[i];
      end else if (rw_s[k]) begin
        mem[k][addr_s[k]] <= dout_s[k];
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rw_s[k]) wcnt[k]++;
      if (rw_s[k] && rw_prev[k]) badrun[k]++;
      rw_prev[k] = rw_s[k];
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic gen(input int k, input int nmin);
    int n;
    logic [4:0] p;
    n = $urandom_range(nmin, 6);
    p = (k == 0) ? 5'd0 : 5'd31;
    for (int i = 0; i < 32; i++) img[i] = 16'($urandom);
    for (int i = 0; i < n; i++) begin
      img[p] = {2'($urandom_range(0, 2)), 5'($urandom_range(12, 30)),
                5'($urandom_range(12, 30)), 4'($urandom)};
      p = p + 5'd1;
    end
    img[p] = {2'b11, 14'($urandom)};
  endtask

  task automatic load(input int k);
    @(negedge clk) ld = k + 1;
    @(negedge clk) ld = 0;
  endtask

  task automatic run(input int k, input string tag);
    int rl, n, cyc, w0, b0;
    logic [4:0]  p;
    logic [15:0] w, o;
    logic [7:0]  a, b, r;
    rl = (k == 0) ? 1 : 3;
    p  = (k == 0) ? 5'd0 : 5'd31;
    load(k);
    foreach (mm[i]) mm[i] = img[i];
    n = 0;
    while (mm[p][15:14] != 2'b11 && n < 40) begin
      w = mm[p];
      o = mm[w[13:9]];
      a = o[15:8];
      b = o[7:0];
      case (w[15:14])
        2'b00:   r = 8'((int'(a) + int'(b)) % 256);
        2'b01:   r = 8'((int'(a) - int'(b) + 256) % 256);
        default: r = 8'((int'(a) * int'(b)) % 256);
      endcase
      mm[w[8:4]] = {8'h00, r};
      p = 5'((int'(p) + 1) % 32);
      n++;
    end
    w0 = wcnt[k];
    b0 = badrun[k];
    start_s[k] = 1'b1;
    @(negedge clk);
    start_s[k] = 1'b0;
    cyc = 1;
    while (!done_s[k] && cyc < 400) begin
      if (cyc == 1) begin
        check({tag, ".busy1"}, 32'(busy_s[k]), 1);
`ifdef ALU_SEQ_PERF_CNT_EN
        check({tag, ".cnt_clr"}, 32'(icnt_s[k]), 0);
`endif
      end
      start_s[k] = (cyc == 2);
      @(negedge clk);
      cyc++;
    end
    start_s[k] = 1'b0;
    check({tag, ".done"}, 32'(done_s[k]), 1);
    check({tag, ".busy"}, 32'(busy_s[k]), 0);
    check({tag, ".cycles"}, 32'(cyc), 32'(n * (2 * rl + 3) + rl + 2));
    check({tag, ".pc"}, 32'(pc_s[k]), 32'(p));
    check({tag, ".writes"}, 32'(wcnt[k] - w0), 32'(n));
    check({tag, ".rw_1cyc"}, 32'(badrun[k] - b0), 0);
`ifdef ALU_SEQ_PERF_CNT_EN
    check({tag, ".instr_count"}, 32'(icnt_s[k]), 32'(n));
`endif
    for (int i = 0; i < 32; i++)
      check($sformatf("%s.mem%0d", tag, i), 32'(mem[k][i]), 32'(mm[i]));
  endtask

  initial begin
    int t;
    logic [4:0] dst;
    reset = 1'b1;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.busy_a", 32'(busy_s[0]), 0);
    check("rst.done_a", 32'(done_s[0]), 0);
    check("rst.rw_a", 32'(rw_s[0]), 0);
    check("rst.pc_a", 32'(pc_s[0]), 0);
    check("rst.pc_b", 32'(pc_s[1]), 31);
    check("rst.addr_b", 32'(addr_s[1]), 0);
    reset = 1'b0;

    foreach (img[i]) img[i] = 16'h0000;
    img[0] = 16'h0A60; img[5] = 16'h0304; img[1] = 16'hC000;
    run(0, "add");
    check("add.mem6", 32'(mem[0][6]), 32'h0007);
    check("add.pc", 32'(pc_s[0]), 1);

    img[0] = 16'h4A70; img[5] = 16'h0304;
    run(0, "sub");
    check("sub.mem7", 32'(mem[0][7]), 32'h00FF);

    img[0] = 16'h8A70; img[5] = 16'h1020;
    run(0, "mul");
    check("mul.mem7", 32'(mem[0][7]), 32'h0000);

    foreach (img[i]) img[i] = 16'h0000;
    img[31] = 16'h0A60; img[5] = 16'h0304; img[0] = 16'hC000;
    run(1, "wrap");
    check("wrap.pc", 32'(pc_s[1]), 0);
    check("wrap.mem6", 32'(mem[1][6]), 32'h0007);

    for (int i = 0; i < 12; i++) begin
      gen(i % 2, 0);
      run(i % 2, $sformatf("rnd%0d", i));
    end

    gen(0, 1);
    load(0);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    t = 0;
    while (!rw_s[0] && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("t1.write_seen", 32'(rw_s[0]), 1);
    dst = addr_s[0];
    reset = 1'b1;
    #1;
    check("t1.busy", 32'(busy_s[0]), 0);
    check("t1.done", 32'(done_s[0]), 0);
    check("t1.rw", 32'(rw_s[0]), 0);
    check("t1.addr", 32'(addr_s[0]), 0);
    check("t1.pc", 32'(pc_s[0]), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t1.no_write", 32'(mem[0][dst]), 32'(img[dst]));

    gen(0, 1);
    run(0, "post_rst");

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
